// File: rtl/fu_cdb_arbiter_pkg.sv
// fu_cdb_arbiter_pkg
//   Shared types and defaults for the completion/CDB arbiter.
//   - SYS_NUM_FU / SYS_NUM_CDB : default FU count and CDB port count
//   - fu_complete_packet_t     : result packet an FU places on the CDB
//   - rr_next()                : modulo-n increment for the round-robin pointer
package fu_cdb_arbiter_pkg;

  localparam int SYS_NUM_FU  = 4;
  localparam int SYS_NUM_CDB = 2;

  typedef struct packed {
    logic [31:0] dest_value;
    logic [5:0]  dest_prn;
    logic [4:0]  rob_idx;
  } fu_complete_packet_t;

  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/fu_cdb_arbiter_rr_multi_picker.sv
// rr_multi_picker
//   Combinational round-robin picker that grants up to NUM_CDB requesters,
//   scanning from start_i upward with wrap.
//   Ports:
//     req_i   : request vector
//     start_i : first index to scan
//     grant_o : granted requesters
//     sel_o   : per-CDB one-hot select; the j-th grant in scan order drives sel_o[j]
//     last_o  : index of the last grant in scan order (start_i when none)
//     cnt_o   : number of grants issued
module rr_multi_picker #(
  parameter int NUM_FU  = 4,
  parameter int NUM_CDB = 2,
  parameter int PTR_W   = 2,
  parameter int CNT_W   = 2
) (
  input  logic [NUM_FU-1:0]               req_i,
  input  logic [PTR_W-1:0]                start_i,
  output logic [NUM_FU-1:0]               grant_o,
  output logic [NUM_CDB-1:0][NUM_FU-1:0]  sel_o,
  output logic [PTR_W-1:0]                last_o,
  output logic [CNT_W-1:0]                cnt_o
);

  always_comb begin
    int idx;
    int cnt;
    grant_o = '0;
    sel_o   = '0;
    last_o  = start_i;
    cnt     = 0;
    idx     = 0;
    for (int j = 0; j < NUM_FU; j++) begin
      // start_i < NUM_FU, so one conditional subtract is a full modulo
      idx = int'(start_i) + j;
      if (idx >= NUM_FU) idx = idx - NUM_FU;
      if (req_i[idx] && (cnt < NUM_CDB)) begin
        grant_o[idx]    = 1'b1;
        sel_o[cnt][idx] = 1'b1;
        last_o          = PTR_W'(idx);
        cnt             = cnt + 1;
      end
    end
    cnt_o = CNT_W'(cnt);
  end

endmodule

// File: rtl/fu_cdb_arbiter.sv
// fu_cdb_arbiter
//   Shares NUM_CDB broadcast ports among NUM_FU completing functional units.
//   Winners are registered onto the CDB one cycle after the grant; losers see
//   fu_hazard in the same cycle and must hold their packet and request.
//   Ports:
//     clk, rst        : clock, asynchronous active-high reset
//     fu_complete_req : per-FU completion request
//     fu_pkt          : per-FU result packet
//     squash          : flush; drops grants and clears the CDB next cycle
//     cdb_stall       : downstream back-pressure; freezes CDB and pointer
//     fu_hazard       : per-FU "not granted, hold" (combinational)
//     cdb_valid/pkt   : registered broadcast ports
//     rr_ptr_dbg      : current round-robin start index
module fu_cdb_arbiter
  import fu_cdb_arbiter_pkg::*;
#(
  parameter int NUM_FU  = SYS_NUM_FU,
  parameter int NUM_CDB = SYS_NUM_CDB,
  parameter int PTR_W   = $clog2(NUM_FU)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_FU-1:0]                    fu_complete_req,
  input  fu_complete_packet_t [NUM_FU-1:0]     fu_pkt,
  input  logic                                 squash,
  input  logic                                 cdb_stall,
  output logic [NUM_FU-1:0]                    fu_hazard,
  output logic [NUM_CDB-1:0]                   cdb_valid,
  output fu_complete_packet_t [NUM_CDB-1:0]    cdb_pkt,
  output logic [PTR_W-1:0]                     rr_ptr_dbg
);

  localparam int CNT_W = $clog2(NUM_CDB + 1);

  logic [PTR_W-1:0]                   rr_ptr_q, rr_ptr_d;
  logic [NUM_CDB-1:0]                 cdb_valid_q, cdb_valid_d;
  fu_complete_packet_t [NUM_CDB-1:0]  cdb_pkt_q, cdb_pkt_d;

  logic [NUM_FU-1:0]                  req_eligible;
  logic [NUM_FU-1:0]                  grant;
  logic [NUM_CDB-1:0][NUM_FU-1:0]     sel;
  logic [PTR_W-1:0]                   last_idx;
  logic [CNT_W-1:0]                   grant_cnt;

  // squash and stall both suppress every grant at the picker input
  assign req_eligible = (squash || cdb_stall) ? '0 : fu_complete_req;

  rr_multi_picker #(
    .NUM_FU  (NUM_FU),
    .NUM_CDB (NUM_CDB),
    .PTR_W   (PTR_W),
    .CNT_W   (CNT_W)
  ) u_picker (
    .req_i   (req_eligible),
    .start_i (rr_ptr_q),
    .grant_o (grant),
    .sel_o   (sel),
    .last_o  (last_idx),
    .cnt_o   (grant_cnt)
  );

  // FUs flush themselves on squash, so nobody is told to hold then
  assign fu_hazard = (rst || squash) ? '0 : (fu_complete_req & ~grant);

  always_comb begin
    cdb_valid_d = cdb_valid_q;
    cdb_pkt_d   = cdb_pkt_q;
    rr_ptr_d    = rr_ptr_q;
    if (squash) begin
      cdb_valid_d = '0;
    end else if (!cdb_stall) begin
      for (int k = 0; k < NUM_CDB; k++) begin
        cdb_valid_d[k] = |sel[k];
        for (int i = 0; i < NUM_FU; i++) begin
          if (sel[k][i]) cdb_pkt_d[k] = fu_pkt[i];
        end
      end
      if (grant_cnt != '0) rr_ptr_d = PTR_W'(rr_next(int'(last_idx), NUM_FU));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cdb_valid_q <= '0;
      cdb_pkt_q   <= '0;
      rr_ptr_q    <= '0;
    end else begin
      cdb_valid_q <= cdb_valid_d;
      cdb_pkt_q   <= cdb_pkt_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign cdb_valid  = cdb_valid_q;
  assign cdb_pkt    = cdb_pkt_q;
  assign rr_ptr_dbg = rr_ptr_q;

endmodule

// File: tb/tb_fu_cdb_arbiter.sv
module tb_fu_cdb_arbiter;
  import fu_cdb_arbiter_pkg::*;

  localparam int NF = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic squash = 1'b0;
  logic cdb_stall = 1'b0;
  logic [NF-1:0] req = '0;
  fu_complete_packet_t [NF-1:0] pkt;
  fu_complete_packet_t [NF-1:0] npkt;

  logic [NF-1:0]              haz2, haz1;
  logic [1:0]                 val2;
  logic [0:0]                 val1;
  fu_complete_packet_t [1:0]  cpkt2;
  fu_complete_packet_t [0:0]  cpkt1;
  logic [1:0]                 ptr2, ptr1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fu_cdb_arbiter #(.NUM_FU(NF), .NUM_CDB(2)) dut2 (
    .clk(clk), .rst(rst), .fu_complete_req(req), .fu_pkt(pkt),
    .squash(squash), .cdb_stall(cdb_stall), .fu_hazard(haz2),
    .cdb_valid(val2), .cdb_pkt(cpkt2), .rr_ptr_dbg(ptr2));

  fu_cdb_arbiter #(.NUM_FU(NF), .NUM_CDB(1)) dut1 (
    .clk(clk), .rst(rst), .fu_complete_req(req), .fu_pkt(pkt),
    .squash(squash), .cdb_stall(cdb_stall), .fu_hazard(haz1),
    .cdb_valid(val1), .cdb_pkt(cpkt1), .rr_ptr_dbg(ptr1));

  // ---------------- behavioural model ----------------
  int m_ptr [2];
  logic m_val [2][2];
  fu_complete_packet_t m_pkt [2][2];
  int run [2][NF];

  function automatic int ncdb(input int m);
    return (m == 0) ? 2 : 1;
  endfunction

  // index of the j-th requester met when scanning from p, or -1 if port j idle
  function automatic int nth_grant(input logic [NF-1:0] r, input int p, input int nc, input int j);
    int c;
    int i;
    c = 0;
    if (j >= nc) return -1;
    for (int s = 0; s < NF; s++) begin
      i = (p + s) % NF;
      if (r[i]) begin
        if (c == j) return i;
        c++;
      end
    end
    return -1;
  endfunction

  function automatic int last_grant(input logic [NF-1:0] r, input int p, input int nc);
    int l;
    l = -1;
    for (int j = 0; j < nc; j++) if (nth_grant(r, p, nc, j) >= 0) l = nth_grant(r, p, nc, j);
    return l;
  endfunction

  function automatic logic [NF-1:0] grant_vec(input logic [NF-1:0] r, input int p, input int nc);
    logic [NF-1:0] g;
    int x;
    g = '0;
    for (int j = 0; j < nc; j++) begin
      x = nth_grant(r, p, nc, j);
      if (x >= 0) g[x] = 1'b1;
    end
    return g;
  endfunction

  task automatic model_step();
    int l;
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        m_ptr[m] = 0;
        for (int k = 0; k < 2; k++) begin
          m_val[m][k] = 1'b0;
          m_pkt[m][k] = '0;
        end
      end else if (squash) begin
        for (int k = 0; k < 2; k++) m_val[m][k] = 1'b0;
      end else if (!cdb_stall) begin
        l = last_grant(req, m_ptr[m], ncdb(m));
        for (int k = 0; k < ncdb(m); k++) begin
          m_val[m][k] = (nth_grant(req, m_ptr[m], ncdb(m), k) >= 0);
          if (m_val[m][k]) m_pkt[m][k] = pkt[nth_grant(req, m_ptr[m], ncdb(m), k)];
        end
        if (l >= 0) m_ptr[m] = (l + 1) % NF;
      end
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    model_step();
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic compare_all();
    logic [NF-1:0] eh, ah;
    for (int m = 0; m < 2; m++) begin
      if (rst || squash) eh = '0;
      else if (cdb_stall) eh = req;
      else eh = req & ~grant_vec(req, m_ptr[m], ncdb(m));
      ah = (m == 0) ? haz2 : haz1;
      chk($sformatf("hazard_cdb%0d", ncdb(m)), 64'(ah), 64'(eh));
      chk($sformatf("rr_ptr_cdb%0d", ncdb(m)), 64'((m == 0) ? ptr2 : ptr1), 64'(m_ptr[m]));
      for (int k = 0; k < ncdb(m); k++) begin
        chk($sformatf("valid_cdb%0d_p%0d", ncdb(m), k),
            64'((m == 0) ? val2[k] : val1[0]), 64'(m_val[m][k]));
        chk($sformatf("pkt_cdb%0d_p%0d", ncdb(m), k),
            64'((m == 0) ? cpkt2[k] : cpkt1[0]), 64'(m_pkt[m][k]));
      end
      // a continuously requesting FU waits at most (NF-1)/NUM_CDB unstalled cycles
      for (int i = 0; i < NF; i++) begin
        if (rst || squash || !req[i]) run[m][i] = 0;
        else if (!cdb_stall) run[m][i] = ah[i] ? run[m][i] + 1 : 0;
        if (run[m][i] > (NF - 1) / ncdb(m)) begin
          errors++;
          $display("FAIL fairness_cdb%0d fu%0d waited=%0d limit=%0d", ncdb(m), i, run[m][i], (NF - 1) / ncdb(m));
          run[m][i] = 0;
        end
      end
    end
  endtask

  initial begin
    for (int m = 0; m < 2; m++) for (int i = 0; i < NF; i++) run[m][i] = 0;
    forever begin
      @(negedge clk);
      compare_all();
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic r, input logic [NF-1:0] q, input logic sq, input logic st);
    @(posedge clk);
    #1;
    rst = r; req = q; squash = sq; cdb_stall = st; pkt = npkt;
    @(negedge clk);
    #1;
  endtask

  initial begin
    logic [NF-1:0] q;
    logic nq;
    for (int i = 0; i < NF; i++) begin
      npkt[i].dest_value = 32'(1 << i);
      npkt[i].dest_prn   = 6'(10 + i);
      npkt[i].rob_idx    = 5'(i);
    end
    pkt = npkt;
    req = 4'b1111;
    rst = 1'b1;
    @(negedge clk); #1;
    chk("reset_haz2", 64'(haz2), 64'h0);
    chk("reset_haz1", 64'(haz1), 64'h0);
    chk("reset_val2", 64'(val2), 64'h0);
    chk("reset_ptr2", 64'(ptr2), 64'h0);

    drive(0, 4'b1111, 0, 0);
    chk("first_haz2", 64'(haz2), 64'b1100);
    chk("first_haz1", 64'(haz1), 64'b1110);
    drive(0, 4'b1111, 0, 0);
    chk("rot1_val2", 64'(val2), 64'b11);
    chk("rot1_p0", 64'(cpkt2[0].dest_value), 64'h1);
    chk("rot1_p1", 64'(cpkt2[1].dest_value), 64'h2);
    chk("rot1_ptr2", 64'(ptr2), 64'd2);
    chk("rot1_haz2", 64'(haz2), 64'b0011);
    drive(0, 4'b1111, 0, 0);
    chk("rot2_p0", 64'(cpkt2[0].dest_value), 64'h4);
    chk("rot2_p1", 64'(cpkt2[1].dest_value), 64'h8);
    chk("rot2_ptr2", 64'(ptr2), 64'd0);
    drive(0, 4'b1111, 0, 0);
    chk("rot3_p0", 64'(cpkt2[0].dest_value), 64'h1);
    chk("rot3_ptr2", 64'(ptr2), 64'd2);

    // single-port ordering with three requesters
    drive(1, 4'b0000, 0, 0);
    drive(0, 4'b0111, 0, 0);
    chk("one_haz_a", 64'(haz1), 64'b0110);
    drive(0, 4'b0111, 0, 0);
    chk("one_haz_b", 64'(haz1), 64'b0101);
    chk("one_pkt_a", 64'(cpkt1[0].dest_value), 64'h1);
    drive(0, 4'b0111, 0, 0);
    chk("one_haz_c", 64'(haz1), 64'b0011);
    chk("one_pkt_b", 64'(cpkt1[0].dest_value), 64'h2);
    drive(0, 4'b0111, 0, 0);
    chk("one_pkt_c", 64'(cpkt1[0].dest_value), 64'h4);

    // sparse request with wrap, then stall, then squash
    drive(1, 4'b0000, 0, 0);
    drive(0, 4'b0001, 0, 0);
    drive(0, 4'b1000, 0, 0);
    chk("sparse_ptr_before", 64'(ptr2), 64'd1);
    chk("sparse_haz", 64'(haz2), 64'b0000);
    drive(0, 4'b0000, 0, 0);
    chk("sparse_ptr_wrap", 64'(ptr2), 64'd0);
    chk("sparse_val", 64'(val2), 64'b01);
    chk("sparse_pkt", 64'(cpkt2[0].dest_value), 64'h8);
    for (int c = 0; c < 3; c++) begin
      drive(0, 4'b0110, 0, 1);
      chk("stall_haz", 64'(haz2), 64'b0110);
      chk("stall_val", 64'(val2), 64'b00);
      chk("stall_ptr", 64'(ptr2), 64'd0);
    end
    drive(0, 4'b0110, 0, 0);
    chk("unstall_haz", 64'(haz2), 64'b0000);
    drive(0, 4'b0001, 1, 0);
    chk("squash_haz", 64'(haz2), 64'b0000);
    chk("squash_val_before", 64'(val2), 64'b11);
    drive(0, 4'b0000, 0, 0);
    chk("squash_val_after", 64'(val2), 64'b00);
    chk("squash_ptr", 64'(ptr2), 64'd3);

    // randomized traffic; FUs tend to hold their request and packet
    for (int c = 0; c < 3000; c++) begin
      q = req;
      for (int i = 0; i < NF; i++) begin
        if (!q[i] || $urandom_range(7) == 0) begin
          nq = 1'($urandom_range(1));
          if (nq && !q[i]) begin
            npkt[i].dest_value = $urandom;
            npkt[i].dest_prn   = 6'($urandom_range(63));
            npkt[i].rob_idx    = 5'($urandom_range(31));
          end
          q[i] = nq;
        end
      end
      drive(($urandom_range(299) == 0), q,
            ($urandom_range(15) == 0), ($urandom_range(5) == 0));
    end
    drive(0, 4'b0000, 0, 0);
    drive(0, 4'b0000, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
